// File: rtl/burst_memory_slave.sv
// Serial-bus burst memory slave: window decode, bit-serial RX/TX FSM and a single-port word array.
// Define MEM_SLAVE_PARITY_EN to append/check an even-parity bit after each serial word.
module burst_memory_slave #(
  parameter int unsigned MEM_OFFSET    = 0,
  parameter int unsigned MEM_SIZE      = 2048,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned BURST_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [ADDRESS_WIDTH-1:0] addr_in,
  input  logic [BURST_WIDTH-1:0]   burst_len_in,
  input  logic                     write_en,
  input  logic                     req,
  output logic                     ready,
  output logic                     done,
  output logic                     err,
  inout  wire                      data_bus_serial
);

  localparam int unsigned LocalAw = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
`ifdef MEM_SLAVE_PARITY_EN
  localparam int unsigned FrameW = DATA_WIDTH + 1;
`else
  localparam int unsigned FrameW = DATA_WIDTH;
`endif
  localparam int unsigned BitCntW = $clog2(FrameW + 1);

  typedef enum logic [2:0] {StIdle, StRx, StFetch, StTx, StDone} state_e;

  state_e                 r_state, w_state_d;
  logic [LocalAw-1:0]     r_addr;
  logic [BURST_WIDTH-1:0] r_len;
  logic [BURST_WIDTH-1:0] r_word_cnt;
  logic [BitCntW-1:0]     r_bit_cnt;
  logic [FrameW-1:0]      r_rx;
  logic [FrameW-1:0]      r_tx;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic                   r_rx_commit;
  logic                   r_rx_ok;
  logic                   r_perr;
  logic [DATA_WIDTH-1:0]  r_mem [MEM_SIZE];

  logic [63:0]            w_addr_ext;
  logic                   w_hit;
  logic [LocalAw-1:0]     w_local;
  logic [LocalAw-1:0]     w_addr_inc;
  logic                   w_bit_last;
  logic                   w_word_last;
  logic [FrameW-1:0]      w_rx_frame;
  logic                   w_par_ok;

  assign w_addr_ext  = 64'(addr_in);
  assign w_hit       = (w_addr_ext >= 64'(MEM_OFFSET)) &&
                       (w_addr_ext < (64'(MEM_OFFSET) + 64'(MEM_SIZE)));
  assign w_local     = LocalAw'(w_addr_ext - 64'(MEM_OFFSET));
  assign w_addr_inc  = (r_addr == LocalAw'(MEM_SIZE - 1)) ? '0 : r_addr + LocalAw'(1);
  assign w_bit_last  = (r_bit_cnt == BitCntW'(FrameW - 1));
  assign w_word_last = (r_word_cnt == r_len);
  // LSB-first: each new bit enters at the top and the frame settles into place after FrameW shifts
  assign w_rx_frame  = (r_rx >> 1) | (FrameW'(data_bus_serial) << (FrameW - 1));

`ifdef MEM_SLAVE_PARITY_EN
  assign w_par_ok = ~^w_rx_frame;
`else
  assign w_par_ok = 1'b1;
`endif

  assign data_bus_serial = (r_state == StTx) ? r_tx[0] : 1'bz;

  always_comb begin
    w_state_d = r_state;
    ready     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (r_state)
      StIdle: begin
        ready = 1'b1;
        if (req) begin
          if (w_hit) w_state_d = write_en ? StRx : StFetch;
          else       err       = 1'b1;
        end
      end
      StRx:    if (w_bit_last && w_word_last) w_state_d = StDone;
      StFetch: w_state_d = StTx;
      StTx:    if (w_bit_last) w_state_d = w_word_last ? StDone : StFetch;
      StDone: begin
        done      = 1'b1;
        err       = r_perr;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_len       <= '0;
      r_word_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_rx        <= '0;
      r_wdata     <= '0;
      r_rx_commit <= 1'b0;
      r_rx_ok     <= 1'b0;
      r_perr      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_rx_commit <= 1'b0;
      // A received word is committed one cycle after its last bit, while the next word streams in
      if (r_rx_commit) r_addr <= w_addr_inc;
      unique case (r_state)
        StIdle: begin
          if (req && w_hit) begin
            r_addr     <= w_local;
            r_len      <= burst_len_in;
            r_word_cnt <= '0;
            r_bit_cnt  <= '0;
            r_perr     <= 1'b0;
          end
        end
        StRx: begin
          r_rx      <= w_rx_frame;
          r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + BitCntW'(1);
          if (w_bit_last) begin
            r_word_cnt  <= r_word_cnt + BURST_WIDTH'(1);
            r_wdata     <= w_rx_frame[DATA_WIDTH-1:0];
            r_rx_commit <= 1'b1;
            r_rx_ok     <= w_par_ok;
            r_perr      <= r_perr | ~w_par_ok;
          end
        end
        StFetch: r_bit_cnt <= '0;
        StTx: begin
          r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + BitCntW'(1);
          if (w_bit_last) begin
            r_addr     <= w_addr_inc;
            r_word_cnt <= r_word_cnt + BURST_WIDTH'(1);
          end
        end
        StDone: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_rx_commit && r_rx_ok) r_mem[r_addr] <= r_wdata;
    if (r_state == StFetch) begin
`ifdef MEM_SLAVE_PARITY_EN
      r_tx <= {^r_mem[r_addr], r_mem[r_addr]};
`else
      r_tx <= r_mem[r_addr];
`endif
    end else if (r_state == StTx) begin
      r_tx <= r_tx >> 1;
    end
  end

endmodule

// File: doc/burst_memory_slave.md
Name: burst_memory_slave

Overview:
- Next-generation bus memory slave: serial-bus slave FSM and memory array in one parametrised block.
- Generalised to any data width; supports multi-word bursts with local address auto-increment and wrap.
- Decodes its own address window and flags out-of-window requests.
- Sits on the serial data bus alongside other slaves; the bus arbiter/master supplies address, direction, burst length and start strobe.

Parameters:
- MEM_OFFSET, 0: first global address served.
- MEM_SIZE, 2048: number of words in the internal array.
- ADDRESS_WIDTH, 12: width of the global address.
- DATA_WIDTH, 8: bits per memory word and per serial frame.
- BURST_WIDTH, 4: width of burst length field; burst = burst_len_in+1 words.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- addr_in  input  ADDRESS_WIDTH  global start address, sampled on accepted req.
- burst_len_in  input  BURST_WIDTH  words minus one, sampled on accepted req.
- write_en  input  1  1 = master writes memory, 0 = master reads; sampled on accepted req.
- req  input  1  one-cycle transaction start strobe.
- ready  output  1  high only in IDLE; slave can accept req.
- done  output  1  one-cycle pulse when transaction completes.
- err  output  1  one-cycle pulse on rejected request (or parity fail, see feature).
- data_bus_serial  inout  1  serial data, LSB first; driven only during read TX bits, else high-Z.

Behaviour:
- Reset values: ready=1, done=0, err=0, data_bus_serial=Z, FSM=IDLE, counters 0. Memory contents are not reset.
- Reset mid-operation: immediate return to IDLE, bus released, partially shifted word discarded, completed words stay written.
- Window check: hit = (addr_in >= MEM_OFFSET) && (addr_in < MEM_OFFSET+MEM_SIZE).
- Local address = addr_in - MEM_OFFSET, truncated to clog2(MEM_SIZE) bits.
- IDLE, req&&hit: latch local address, length and direction; ready->0 next cycle; go to RX (write) or FETCH (read).
- IDLE, req&&!hit: err=1 for one cycle; ready stays 1; no other effect.
- req while ready=0: ignored.
- RX: samples data_bus_serial on each of the DATA_WIDTH cycles following acceptance (bit 0 first) into a shift register. In the cycle after the last bit, the word is written to mem[addr], addr increments and the word counter increments.
  - More words remain: stay in RX; the next word's bit 0 arrives in that same cycle (no gap).
  - Last word: go to DONE.
- FETCH: one cycle; synchronous array read of mem[addr] into the TX shift register. Go to TX.
- TX: drives bit i of the word on cycle i (DATA_WIDTH cycles); bus returns to Z the cycle after the last bit. addr increments.
  - More words remain: FETCH.
  - Last word: DONE.
- Read word spacing: DATA_WIDTH+1 cycles, 1 Z cycle between words.
- DONE: done=1 for one cycle, then IDLE with ready=1 the following cycle.
- Address wrap: local address MEM_SIZE-1 increments to 0 within a burst; bursts never leave the window.
- Latency (BURST=1, DATA_WIDTH=8):
  - Write: req at cycle 0, bits cycles 1-8, array write cycle 9, done cycle 9, ready cycle 10.
  - Read: FETCH cycle 1, bits cycles 2-9, done cycle 10, ready cycle 11.
- Array: single-port, synchronous read and write, inferred from a reg array of MEM_SIZE x DATA_WIDTH.

Optional Feature:
- Macro: MEM_SLAVE_PARITY_EN.
- Defined: each serial frame is DATA_WIDTH+1 bits, with an even-parity bit following the MSB.
  - TX appends the parity of the word.
  - RX checks parity; a mismatching word is not written, though the address still increments.
  - An error flag is latched and err pulses together with done; the burst still runs to completion.
  - All frame-length latencies grow by one cycle per word.
- Undefined: no parity bit, and err fires only for window misses.

Test Plan:
- Write 1 word: req, addr_in=0x005, write_en=1, len=0, serial 0xA5 LSB first -> done at cycle 9; readback of 0x005 returns 0xA5 on bus cycles 2-9.
- Burst write then read: len=3 at 0x010, words 0x11,0x22,0x33,0x44 back-to-back -> done after 4x8+1 cycles; read burst returns same 4 words, 1 Z cycle between each.
- Wrap: len=1 write at local 2047 with 0xDE,0xAD -> mem[2047]=0xDE, mem[0]=0xAD.
- Window miss: MEM_OFFSET=0x800, req addr 0x100 -> err one cycle, ready stays 1, bus Z, memory unchanged.
- Reset mid-burst: rstn low during 2nd word of len=3 write -> ready=1 and bus Z immediately; 1st word retained, 2nd not written.
- Parity (MEM_SLAVE_PARITY_EN): write 0x01 with parity bit 0 -> word not written, err and done pulse together.
